// File: rtl/clock_time_ctrl.sv
// ============================================================================
// clock_time_ctrl
// ----------------------------------------------------------------------------
// Time-of-day sequencer for a cascaded BCD clock (ss, mm mod 60; hh mod HOURS).
// A 1 Hz tick advances the whole chain in a single clock edge, so every carry
// between fields is synchronous and there is no ripple across cycles. A small
// mode FSM (RUN -> SET_HR -> SET_MIN -> RUN) stops the chain and lets a single
// increment button set the hours and then the minutes.
//
// Parameters
//   HOURS     hour modulus, 24 (00..23) or 12 (00..11)
// Ports
//   clk       system clock, rising-edge active
//   rst_n     asynchronous reset, active-low
//   tick      1-cycle pulse, advances seconds in RUN, toggles blink in SET
//   mode_btn  1-cycle pulse, advances the mode FSM
//   inc_btn   1-cycle pulse, increments the selected field in SET modes
//   sec_lo/sec_hi, min_lo/min_hi, hr_lo/hr_hi   BCD time digits (registers)
//   mode      00 RUN, 01 SET_HR, 10 SET_MIN
//   blink     display-blank strobe for the field being set
//   day_co    1-cycle pulse when RUN wraps from HOURS-1:59:59 to 00:00:00
// ============================================================================
module clock_time_ctrl #(
    parameter int HOURS = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       mode_btn,
    input  logic       inc_btn,
    output logic [3:0] sec_lo,
    output logic [2:0] sec_hi,
    output logic [3:0] min_lo,
    output logic [2:0] min_hi,
    output logic [3:0] hr_lo,
    output logic [1:0] hr_hi,
    output logic [1:0] mode,
    output logic       blink,
    output logic       day_co
);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        SET_HR  = 2'b01,
        SET_MIN = 2'b10
    } mode_e;

    // Last legal hour split into BCD digits (23 -> 2/3, 11 -> 1/1).
    localparam logic [1:0] HR_MAX_HI = 2'((HOURS - 1) / 10);
    localparam logic [3:0] HR_MAX_LO = 4'((HOURS - 1) % 10);

    mode_e      mode_q, mode_d;
    logic [3:0] sec_lo_q, sec_lo_d;
    logic [2:0] sec_hi_q, sec_hi_d;
    logic [3:0] min_lo_q, min_lo_d;
    logic [2:0] min_hi_q, min_hi_d;
    logic [3:0] hr_lo_q, hr_lo_d;
    logic [1:0] hr_hi_q, hr_hi_d;
    logic       blink_q, blink_d;
    logic       day_co_q, day_co_d;

    logic sec_last, min_last, hr_last;
    logic adv_sec, adv_min, adv_hr, clr_sec;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one
        // unassigned; a missing default here would infer a latch.
        mode_d   = mode_q;
        sec_lo_d = sec_lo_q;
        sec_hi_d = sec_hi_q;
        min_lo_d = min_lo_q;
        min_hi_d = min_hi_q;
        hr_lo_d  = hr_lo_q;
        hr_hi_d  = hr_hi_q;
        blink_d  = blink_q;
        day_co_d = 1'b0;
        adv_sec  = 1'b0;
        adv_min  = 1'b0;
        adv_hr   = 1'b0;
        clr_sec  = 1'b0;

        sec_last = (sec_hi_q == 3'd5) && (sec_lo_q == 4'd9);
        min_last = (min_hi_q == 3'd5) && (min_lo_q == 4'd9);
        hr_last  = (hr_hi_q == HR_MAX_HI) && (hr_lo_q == HR_MAX_LO);

        case (mode_q)
            RUN: begin
                blink_d = 1'b0;
                // All carries are decided from the current state, so the whole
                // cascade lands in the same edge as the tick.
                if (tick) begin
                    adv_sec  = 1'b1;
                    adv_min  = sec_last;
                    adv_hr   = sec_last && min_last;
                    day_co_d = sec_last && min_last && hr_last;
                end
                if (mode_btn) mode_d = SET_HR;
            end
            SET_HR: begin
                // mode_btn takes precedence; a coincident inc_btn is dropped.
                if (mode_btn) begin
                    mode_d  = SET_MIN;
                    blink_d = 1'b0;
                end else if (inc_btn) begin
                    adv_hr  = 1'b1;
                    blink_d = 1'b0;
                end else if (tick) begin
                    blink_d = ~blink_q;
                end
            end
            SET_MIN: begin
                if (mode_btn) begin
                    mode_d  = RUN;
                    blink_d = 1'b0;
                    clr_sec = 1'b1;
                end else if (inc_btn) begin
                    adv_min = 1'b1;
                    blink_d = 1'b0;
                end else if (tick) begin
                    blink_d = ~blink_q;
                end
            end
            default: begin
                mode_d  = RUN;
                blink_d = 1'b0;
            end
        endcase

        if (adv_sec) begin
            if (sec_lo_q == 4'd9) begin
                sec_lo_d = 4'd0;
                sec_hi_d = (sec_hi_q == 3'd5) ? 3'd0 : sec_hi_q + 3'd1;
            end else begin
                sec_lo_d = sec_lo_q + 4'd1;
            end
        end

        // Minute and hour increments wrap locally; carries only come from the
        // RUN cascade above, never from a SET-mode increment.
        if (adv_min) begin
            if (min_lo_q == 4'd9) begin
                min_lo_d = 4'd0;
                min_hi_d = (min_hi_q == 3'd5) ? 3'd0 : min_hi_q + 3'd1;
            end else begin
                min_lo_d = min_lo_q + 4'd1;
            end
        end

        if (adv_hr) begin
            if (hr_last) begin
                hr_lo_d = 4'd0;
                hr_hi_d = 2'd0;
            end else if (hr_lo_q == 4'd9) begin
                hr_lo_d = 4'd0;
                hr_hi_d = hr_hi_q + 2'd1;
            end else begin
                hr_lo_d = hr_lo_q + 4'd1;
            end
        end

        if (clr_sec) begin
            sec_lo_d = 4'd0;
            sec_hi_d = 3'd0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values computed above, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= RUN;
            sec_lo_q <= 4'd0;
            sec_hi_q <= 3'd0;
            min_lo_q <= 4'd0;
            min_hi_q <= 3'd0;
            hr_lo_q  <= 4'd0;
            hr_hi_q  <= 2'd0;
            blink_q  <= 1'b0;
            day_co_q <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            sec_lo_q <= sec_lo_d;
            sec_hi_q <= sec_hi_d;
            min_lo_q <= min_lo_d;
            min_hi_q <= min_hi_d;
            hr_lo_q  <= hr_lo_d;
            hr_hi_q  <= hr_hi_d;
            blink_q  <= blink_d;
            day_co_q <= day_co_d;
        end
    end

    assign sec_lo = sec_lo_q;
    assign sec_hi = sec_hi_q;
    assign min_lo = min_lo_q;
    assign min_hi = min_hi_q;
    assign hr_lo  = hr_lo_q;
    assign hr_hi  = hr_hi_q;
    assign mode   = mode_q;
    assign blink  = blink_q;
    assign day_co = day_co_q;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// ============================================================================
// tb_clock_time_ctrl
// ----------------------------------------------------------------------------
// Drives a 24-hour and a 12-hour instance with the same directed stimulus.
// A time-of-day model (plain integer hh/mm/ss per instance) predicts every
// output and is compared on each falling edge; literal expectations at key
// points pin both the DUTs and the model.
// ============================================================================
module tb_clock_time_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tick = 1'b0;
    logic mode_btn = 1'b0;
    logic inc_btn = 1'b0;

    always #5 clk = ~clk;

    logic [3:0] a_sec_lo, a_min_lo, a_hr_lo, b_sec_lo, b_min_lo, b_hr_lo;
    logic [2:0] a_sec_hi, a_min_hi, b_sec_hi, b_min_hi;
    logic [1:0] a_hr_hi, b_hr_hi, a_mode, b_mode;
    logic       a_blink, b_blink, a_day_co, b_day_co;

    clock_time_ctrl #(.HOURS(24)) dut_a (
        .clk(clk), .rst_n(rst_n), .tick(tick), .mode_btn(mode_btn), .inc_btn(inc_btn),
        .sec_lo(a_sec_lo), .sec_hi(a_sec_hi), .min_lo(a_min_lo), .min_hi(a_min_hi),
        .hr_lo(a_hr_lo), .hr_hi(a_hr_hi), .mode(a_mode), .blink(a_blink), .day_co(a_day_co)
    );

    clock_time_ctrl #(.HOURS(12)) dut_b (
        .clk(clk), .rst_n(rst_n), .tick(tick), .mode_btn(mode_btn), .inc_btn(inc_btn),
        .sec_lo(b_sec_lo), .sec_hi(b_sec_hi), .min_lo(b_min_lo), .min_hi(b_min_hi),
        .hr_lo(b_hr_lo), .hr_hi(b_hr_hi), .mode(b_mode), .blink(b_blink), .day_co(b_day_co)
    );

    logic [19:0] a_time, b_time;
    assign a_time = {a_hr_hi, a_hr_lo, a_min_hi, a_min_lo, a_sec_hi, a_sec_lo};
    assign b_time = {b_hr_hi, b_hr_lo, b_min_hi, b_min_lo, b_sec_hi, b_sec_lo};

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Packs individual decimal digits into the display layout.
    function automatic logic [19:0] digits(input int h1, h0, m1, m0, s1, s0);
        return {2'(h1), 4'(h0), 3'(m1), 4'(m0), 3'(s1), 4'(s0)};
    endfunction

    function automatic logic [19:0] as_time(input int h, m, s);
        return digits(h / 10, h % 10, m / 10, m % 10, s / 10, s % 10);
    endfunction

    // ---------------- behavioural model: index 0 = 24 h, 1 = 12 h ----------
    int mods[2] = '{24, 12};
    int m_h[2], m_m[2], m_s[2], m_md[2], m_bl[2], m_dc[2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_h[k] = 0; m_m[k] = 0; m_s[k] = 0;
                m_md[k] = 0; m_bl[k] = 0; m_dc[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                m_dc[k] = 0;
                if (m_md[k] == 0) begin
                    m_bl[k] = 0;
                    if (tick) begin
                        int t;
                        t = (m_h[k] * 3600 + m_m[k] * 60 + m_s[k]) + 1;
                        if (t == mods[k] * 3600) begin
                            t = 0;
                            m_dc[k] = 1;
                        end
                        m_h[k] = t / 3600;
                        m_m[k] = (t / 60) % 60;
                        m_s[k] = t % 60;
                    end
                    if (mode_btn) m_md[k] = 1;
                end else if (mode_btn) begin
                    if (m_md[k] == 2) m_s[k] = 0;
                    m_md[k] = (m_md[k] == 1) ? 2 : 0;
                    m_bl[k] = 0;
                end else if (inc_btn) begin
                    if (m_md[k] == 1) m_h[k] = (m_h[k] + 1) % mods[k];
                    else              m_m[k] = (m_m[k] + 1) % 60;
                    m_bl[k] = 0;
                end else if (tick) begin
                    m_bl[k] = 1 - m_bl[k];
                end
            end
        end
    end

    // ---------------- per-cycle compare ------------------------------------
    logic checking_on = 1'b0;

    always @(negedge clk) begin
        if (checking_on) begin
            check("a_time",  int'(a_time),   int'(as_time(m_h[0], m_m[0], m_s[0])));
            check("a_mode",  int'(a_mode),   m_md[0]);
            check("a_blink", int'(a_blink),  m_bl[0]);
            check("a_dayco", int'(a_day_co), m_dc[0]);
            check("b_time",  int'(b_time),   int'(as_time(m_h[1], m_m[1], m_s[1])));
            check("b_mode",  int'(b_mode),   m_md[1]);
            check("b_blink", int'(b_blink),  m_bl[1]);
            check("b_dayco", int'(b_day_co), m_dc[1]);
        end
    end

    // ---------------- stimulus helpers (called at negedge + 1) -------------
    task automatic pulse(input logic t, input logic m, input logic i);
        tick = t; mode_btn = m; inc_btn = i;
        @(negedge clk); #1;
        tick = 1'b0; mode_btn = 1'b0; inc_btn = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk); #1;
    endtask

    task automatic pulse_gap(input logic t, input logic m, input logic i);
        pulse(t, m, i);
        idle();
    endtask

    task automatic ticks(input int n);
        repeat (n) pulse_gap(1'b1, 1'b0, 1'b0);
    endtask

    task automatic incs(input int n);
        repeat (n) pulse_gap(1'b0, 1'b0, 1'b1);
    endtask

    task automatic mode_press();
        pulse_gap(1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        checking_on = 1'b1;
        check("rst_time", int'(a_time), 0);
        check("rst_mode", int'(a_mode), 0);
        rst_n = 1'b1;
        idle();

        // Reset mid-count, observed before any clock edge.
        ticks(10);
        check("pre_rst_time", int'(a_time), int'(digits(0, 0, 0, 0, 1, 0)));
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_a", int'(a_time), 0);
        check("async_rst_b", int'(b_time), 0);
        check("async_rst_mode", int'(a_mode), 0);
        idle();
        rst_n = 1'b1;
        idle();

        // Set hours: seconds frozen, ticks only toggle blink.
        ticks(3);
        mode_press();
        check("set_hr_mode", int'(a_mode), 1);
        pulse(1'b1, 1'b0, 1'b0);
        check("set_tick_blink", int'(a_blink), 1);
        check("set_tick_time", int'(a_time), int'(digits(0, 0, 0, 0, 0, 3)));
        idle();
        incs(25);
        check("hr25_a", int'(a_time), int'(digits(0, 1, 0, 0, 0, 3)));
        check("hr25_b", int'(b_time), int'(digits(0, 1, 0, 0, 0, 3)));
        check("inc_blink", int'(a_blink), 0);
        ticks(2);
        check("set_hold_sec", int'(a_time), int'(digits(0, 1, 0, 0, 0, 3)));

        // Set minutes and exit (seconds cleared on exit).
        mode_press();
        check("set_min_mode", int'(a_mode), 2);
        incs(61);
        check("min61", int'(a_time), int'(digits(0, 1, 0, 1, 0, 3)));
        mode_press();
        check("exit_mode", int'(a_mode), 0);
        check("exit_time", int'(a_time), int'(digits(0, 1, 0, 1, 0, 0)));

        // Collisions.
        mode_press();
        pulse(1'b0, 1'b1, 1'b1);
        check("col_mode", int'(a_mode), 2);
        check("col_hours", int'(a_time), int'(digits(0, 1, 0, 1, 0, 0)));
        idle();
        mode_press();
        ticks(5);
        pulse(1'b1, 1'b1, 1'b0);
        check("tm_time", int'(a_time), int'(digits(0, 1, 0, 1, 0, 6)));
        check("tm_mode", int'(a_mode), 1);
        idle();

        // Full cascade: A goes to 23:59, B (mod 12) lands on 11:59.
        incs(22);
        mode_press();
        incs(58);
        mode_press();
        ticks(59);
        check("pre_day_a", int'(a_time), int'(digits(2, 3, 5, 9, 5, 9)));
        check("pre_day_b", int'(b_time), int'(digits(1, 1, 5, 9, 5, 9)));
        check("model_h_a", m_h[0], 23);
        check("model_h_b", m_h[1], 11);
        pulse(1'b1, 1'b0, 1'b0);
        check("day_a", int'(a_time), 0);
        check("day_b", int'(b_time), 0);
        check("dayco_a_hi", int'(a_day_co), 1);
        check("dayco_b_hi", int'(b_day_co), 1);
        idle();
        check("dayco_a_lo", int'(a_day_co), 0);
        check("dayco_b_lo", int'(b_day_co), 0);

        // Minute wraps.
        mode_press();
        mode_press();
        incs(9);
        mode_press();
        ticks(59);
        pulse(1'b1, 1'b0, 1'b0);
        check("wrap_0010", int'(a_time), int'(digits(0, 0, 1, 0, 0, 0)));
        idle();
        mode_press();
        mode_press();
        incs(49);
        mode_press();
        ticks(59);
        check("pre_0100", int'(a_time), int'(digits(0, 0, 5, 9, 5, 9)));
        pulse(1'b1, 1'b0, 1'b0);
        check("wrap_0100_a", int'(a_time), int'(digits(0, 1, 0, 0, 0, 0)));
        check("wrap_0100_b", int'(b_time), int'(digits(0, 1, 0, 0, 0, 0)));
        check("no_dayco", int'(a_day_co), 0);
        check("model_m_a", m_m[0], 0);
        idle();

        checking_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
